// File: rtl/pipe_ctrl.sv
// Pipeline hazard/jump/bus-hold controller: per-stage hold/flush, jump steering, stall counter.
// Optional operand forwarding is enabled by defining PIPE_CTRL_FORWARD_EN.
module pipe_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_flag_i,
  input  logic [XLEN-1:0]       jump_addr_i,
  input  logic [REG_AW-1:0]     id_rs1_i,
  input  logic [REG_AW-1:0]     id_rs2_i,
  input  logic                  id_rs1_re_i,
  input  logic                  id_rs2_re_i,
  input  logic [REG_AW-1:0]     ex_rd_i,
  input  logic                  ex_we_i,
  input  logic                  ex_is_load_i,
  input  logic [REG_AW-1:0]     mem_rd_i,
  input  logic                  mem_we_i,
  input  logic                  bus_hold_req_i,
  output logic                  jump_flag_o,
  output logic [XLEN-1:0]       jump_addr_o,
  output logic [NUM_STAGES-1:0] hold_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic [1:0]            fwd_rs1_sel_o,
  output logic [1:0]            fwd_rs2_sel_o,
  output logic [1:0]            state_o,
  output logic [15:0]           stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BUS_HOLD   = 2'd2,
    JUMP_PEND  = 2'd3
  } state_e;

  // Jump kills the stages behind the pc (bits 1..FLUSH_DEPTH); a hazard freezes pc/if_id and bubbles id_ex.
  localparam logic [NUM_STAGES-1:0] JUMP_FLUSH =
    NUM_STAGES'(((1 << (FLUSH_DEPTH + 1)) - 1) & ~1);
  localparam logic [NUM_STAGES-1:0] HAZ_HOLD  = NUM_STAGES'(3);
  localparam logic [NUM_STAGES-1:0] HAZ_FLUSH = NUM_STAGES'(4);

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [XLEN-1:0]   pend_addr_q, pend_addr_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic              rs1_ex, rs2_ex, rs1_mem, rs2_mem, haz;
  logic [1:0]        fwd1, fwd2;
  logic              jf;
  logic [XLEN-1:0]   ja;
  logic [NUM_STAGES-1:0] hold, flush;

  assign rs1_ex  = id_rs1_re_i && (id_rs1_i != '0) && ex_we_i  && (ex_rd_i  == id_rs1_i);
  assign rs2_ex  = id_rs2_re_i && (id_rs2_i != '0) && ex_we_i  && (ex_rd_i  == id_rs2_i);
  assign rs1_mem = id_rs1_re_i && (id_rs1_i != '0) && mem_we_i && (mem_rd_i == id_rs1_i);
  assign rs2_mem = id_rs2_re_i && (id_rs2_i != '0) && mem_we_i && (mem_rd_i == id_rs2_i);

`ifdef PIPE_CTRL_FORWARD_EN
  assign haz  = (rs1_ex | rs2_ex) & ex_is_load_i;
  assign fwd1 = (rs1_ex && !ex_is_load_i) ? 2'd1 : (rs1_mem ? 2'd2 : 2'd0);
  assign fwd2 = (rs2_ex && !ex_is_load_i) ? 2'd1 : (rs2_mem ? 2'd2 : 2'd0);
`else
  assign haz  = ((rs1_ex | rs2_ex) & ex_is_load_i) | rs1_ex | rs2_ex | rs1_mem | rs2_mem;
  assign fwd1 = 2'd0;
  assign fwd2 = 2'd0;
`endif

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    hold        = '0;
    flush       = '0;
    jf          = 1'b0;
    ja          = '0;
    case (state_q)
      BUS_HOLD: begin
        hold = '1;
        if (jump_flag_i) begin
          pend_d      = 1'b1;
          pend_addr_d = jump_addr_i;
        end
        state_d = pend_d ? JUMP_PEND : RUN;
      end
      JUMP_PEND: begin
        jf      = 1'b1;
        ja      = pend_addr_q;
        flush   = JUMP_FLUSH;
        pend_d  = 1'b0;
        state_d = RUN;
      end
      default: begin
        if (jump_flag_i) begin
          jf      = 1'b1;
          ja      = jump_addr_i;
          flush   = JUMP_FLUSH;
          state_d = RUN;
        end else if (haz) begin
          hold    = HAZ_HOLD;
          flush   = HAZ_FLUSH;
          state_d = LOAD_STALL;
        end else begin
          state_d = RUN;
        end
      end
    endcase
    // Bus hold outranks everything for the next-state choice.
    if (bus_hold_req_i) state_d = BUS_HOLD;
    hold = hold & ~flush;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|hold) && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Combinational outputs are gated so reset silences them without waiting for a clock.
  assign jump_flag_o   = rst & jf;
  assign jump_addr_o   = (rst && jf) ? ja : '0;
  assign hold_o        = rst ? hold  : '0;
  assign flush_o       = rst ? flush : '0;
  assign fwd_rs1_sel_o = rst ? fwd1  : 2'd0;
  assign fwd_rs2_sel_o = rst ? fwd2  : 2'd0;
  assign state_o       = state_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, hazards, forwarding, jumps, bus hold and async reset.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [4:0]  id_rs1_i, id_rs2_i;
  logic        id_rs1_re_i, id_rs2_re_i;
  logic [4:0]  ex_rd_i;
  logic        ex_we_i, ex_is_load_i;
  logic [4:0]  mem_rd_i;
  logic        mem_we_i;
  logic        bus_hold_req_i;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [4:0]  hold_o, flush_o;
  logic [1:0]  fwd_rs1_sel_o, fwd_rs2_sel_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .jump_flag_i    (jump_flag_i),
    .jump_addr_i    (jump_addr_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_rs1_re_i    (id_rs1_re_i),
    .id_rs2_re_i    (id_rs2_re_i),
    .ex_rd_i        (ex_rd_i),
    .ex_we_i        (ex_we_i),
    .ex_is_load_i   (ex_is_load_i),
    .mem_rd_i       (mem_rd_i),
    .mem_we_i       (mem_we_i),
    .bus_hold_req_i (bus_hold_req_i),
    .jump_flag_o    (jump_flag_o),
    .jump_addr_o    (jump_addr_o),
    .hold_o         (hold_o),
    .flush_o        (flush_o),
    .fwd_rs1_sel_o  (fwd_rs1_sel_o),
    .fwd_rs2_sel_o  (fwd_rs2_sel_o),
    .state_o        (state_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic clr_inputs();
    jump_flag_i    = 1'b0;
    jump_addr_i    = 32'h0;
    id_rs1_i       = 5'd0;
    id_rs2_i       = 5'd0;
    id_rs1_re_i    = 1'b0;
    id_rs2_re_i    = 1'b0;
    ex_rd_i        = 5'd0;
    ex_we_i        = 1'b0;
    ex_is_load_i   = 1'b0;
    mem_rd_i       = 5'd0;
    mem_we_i       = 1'b0;
    bus_hold_req_i = 1'b0;
  endtask

  // Advance past the next rising edge; inputs change here, checks follow #1 later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
  endtask

  initial begin
    clr_inputs();
    rst = 1'b0;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h55;
    #3;
    chk("rst_jump_flag", {31'd0, jump_flag_o}, 32'd0);
    chk("rst_jump_addr", jump_addr_o, 32'd0);
    chk("rst_hold", {27'd0, hold_o}, 32'd0);
    chk("rst_flush", {27'd0, flush_o}, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_cnt", {16'd0, stall_cnt_o}, 32'd0);
    clr_inputs();
    tick();
    rst = 1'b1;
    tick();
    settle();
    chk("idle_hold", {27'd0, hold_o}, 32'd0);

    // Load-use on rs1
    ex_rd_i = 5'd5; ex_we_i = 1'b1; ex_is_load_i = 1'b1;
    id_rs1_i = 5'd5; id_rs1_re_i = 1'b1;
    settle();
    chk("lu_hold", {27'd0, hold_o}, 32'b00011);
    chk("lu_flush", {27'd0, flush_o}, 32'b00100);
    tick();
    ex_we_i = 1'b0; ex_is_load_i = 1'b0;
    settle();
    chk("lu_state", {30'd0, state_o}, 32'd1);
    chk("lu_clear_hold", {27'd0, hold_o}, 32'd0);
    tick();
    settle();
    chk("lu_back_run", {30'd0, state_o}, 32'd0);
    chk("lu_cnt", {16'd0, stall_cnt_o}, 32'd1);

    // Index 0 and disabled read never match
    clr_inputs();
    ex_rd_i = 5'd0; ex_we_i = 1'b1; ex_is_load_i = 1'b1;
    id_rs1_i = 5'd0; id_rs1_re_i = 1'b1;
    settle();
    chk("x0_nomatch", {27'd0, hold_o}, 32'd0);
    ex_rd_i = 5'd9; id_rs1_i = 5'd9; id_rs1_re_i = 1'b0;
    settle();
    chk("re0_nomatch", {27'd0, hold_o}, 32'd0);
    tick();

    // ex and mem both write rs2
    clr_inputs();
    ex_rd_i = 5'd7; ex_we_i = 1'b1;
    mem_rd_i = 5'd7; mem_we_i = 1'b1;
    id_rs2_i = 5'd7; id_rs2_re_i = 1'b1;
    settle();
`ifdef PIPE_CTRL_FORWARD_EN
    chk("fwd_ex_sel", {30'd0, fwd_rs2_sel_o}, 32'd1);
    chk("fwd_ex_hold", {27'd0, hold_o}, 32'd0);
`else
    chk("nofwd_ex_sel", {30'd0, fwd_rs2_sel_o}, 32'd0);
    chk("nofwd_ex_hold", {27'd0, hold_o}, 32'b00011);
`endif
    ex_we_i = 1'b0;
    settle();
`ifdef PIPE_CTRL_FORWARD_EN
    chk("fwd_mem_sel", {30'd0, fwd_rs2_sel_o}, 32'd2);
    chk("fwd_mem_hold", {27'd0, hold_o}, 32'd0);
`else
    chk("nofwd_mem_hold", {27'd0, hold_o}, 32'b00011);
    chk("nofwd_mem_flush", {27'd0, flush_o}, 32'b00100);
`endif
    tick();
    clr_inputs();
    tick();
    settle();
    chk("after_fwd_state", {30'd0, state_o}, 32'd0);

    // Jump concurrent with load-use
    ex_rd_i = 5'd5; ex_we_i = 1'b1; ex_is_load_i = 1'b1;
    id_rs1_i = 5'd5; id_rs1_re_i = 1'b1;
    jump_flag_i = 1'b1; jump_addr_i = 32'h1234;
    settle();
    chk("jlu_flag", {31'd0, jump_flag_o}, 32'd1);
    chk("jlu_addr", jump_addr_o, 32'h1234);
    chk("jlu_flush", {27'd0, flush_o}, 32'b00110);
    chk("jlu_hold", {27'd0, hold_o}, 32'd0);
    tick();
    clr_inputs();
    jump_addr_i = 32'hDEAD;
    settle();
    chk("jlu_state", {30'd0, state_o}, 32'd0);
    chk("noflag_addr0", jump_addr_o, 32'd0);

    // Jumps latched during a 4-cycle bus hold
    clr_inputs();
    pulse_reset();
    settle();
    chk("bh_cnt_start", {16'd0, stall_cnt_o}, 32'd0);
    tick();
    bus_hold_req_i = 1'b1;
    settle();
    chk("bh_c0_state", {30'd0, state_o}, 32'd0);
    tick();
    jump_flag_i = 1'b1; jump_addr_i = 32'h80;
    settle();
    chk("bh_c1_state", {30'd0, state_o}, 32'd2);
    chk("bh_c1_hold", {27'd0, hold_o}, 32'b11111);
    chk("bh_c1_flag", {31'd0, jump_flag_o}, 32'd0);
    chk("bh_c1_flush", {27'd0, flush_o}, 32'd0);
    tick();
    jump_addr_i = 32'h100;
    settle();
    chk("bh_c2_flag", {31'd0, jump_flag_o}, 32'd0);
    chk("bh_c2_addr", jump_addr_o, 32'd0);
    tick();
    jump_flag_i = 1'b0; jump_addr_i = 32'h0;
    settle();
    chk("bh_c3_state", {30'd0, state_o}, 32'd2);
    tick();
    bus_hold_req_i = 1'b0;
    settle();
    chk("bh_c4_hold", {27'd0, hold_o}, 32'b11111);
    chk("bh_c4_flag", {31'd0, jump_flag_o}, 32'd0);
    tick();
    settle();
    chk("jp_state", {30'd0, state_o}, 32'd3);
    chk("jp_flag", {31'd0, jump_flag_o}, 32'd1);
    chk("jp_addr", jump_addr_o, 32'h100);
    chk("jp_flush", {27'd0, flush_o}, 32'b00110);
    chk("jp_hold", {27'd0, hold_o}, 32'd0);
    tick();
    settle();
    chk("jp_done_state", {30'd0, state_o}, 32'd0);
    chk("jp_done_flag", {31'd0, jump_flag_o}, 32'd0);
    chk("bh_cnt", {16'd0, stall_cnt_o}, 32'd4);

    // Async reset discards a pending jump
    bus_hold_req_i = 1'b1;
    tick();
    jump_flag_i = 1'b1; jump_addr_i = 32'h300;
    tick();
    jump_flag_i = 1'b0;
    settle();
    chk("ar_pre_state", {30'd0, state_o}, 32'd2);
    rst = 1'b0;
    #1;
    chk("ar_state", {30'd0, state_o}, 32'd0);
    chk("ar_hold", {27'd0, hold_o}, 32'd0);
    chk("ar_flush", {27'd0, flush_o}, 32'd0);
    chk("ar_cnt", {16'd0, stall_cnt_o}, 32'd0);
    bus_hold_req_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    settle();
    chk("ar_rel_flag0", {31'd0, jump_flag_o}, 32'd0);
    chk("ar_rel_state0", {30'd0, state_o}, 32'd0);
    tick();
    settle();
    chk("ar_rel_flag1", {31'd0, jump_flag_o}, 32'd0);
    chk("ar_rel_cnt", {16'd0, stall_cnt_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of pipeline registers controlled (bit 0 = pc, 1 = if_id, 2 = id_ex, 3 = ex_mem, 4 = mem_wb).
REQ-002 SHALL have parameter XLEN, default 32, address width.
REQ-003 SHALL have parameter REG_AW, default 5, register-index width.
REQ-004 SHALL have parameter FLUSH_DEPTH, default 2, number of stages (bits 1..FLUSH_DEPTH) flushed on a jump; legal range 1..NUM_STAGES-2.
REQ-005 Ports, clock and reset first:
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-low reset
  jump_flag_i  in  1  jump request from the decode/execute stage
  jump_addr_i  in  XLEN  jump target
  id_rs1_i, id_rs2_i  in  REG_AW  decode-stage source indices
  id_rs1_re_i, id_rs2_re_i  in  1  source read enables
  ex_rd_i  in  REG_AW; ex_we_i  in  1; ex_is_load_i  in  1  execute-stage destination info
  mem_rd_i  in  REG_AW; mem_we_i  in  1  memory-stage destination info
  bus_hold_req_i  in  1  data/instruction memory busy, level
  jump_flag_o  out  1; jump_addr_o  out  XLEN  to the pc register
  hold_o  out  NUM_STAGES  per-stage hold (register keeps its value)
  flush_o  out  NUM_STAGES  per-stage flush (register loads a NOP bubble)
  fwd_rs1_sel_o, fwd_rs2_sel_o  out  2  0 = regfile, 1 = ex result, 2 = mem result
  state_o  out  2  current FSM state
  stall_cnt_o  out  16  stall-cycle performance counter

Function
REQ-006 FSM states SHALL be RUN=0, LOAD_STALL=1, BUS_HOLD=2, JUMP_PEND=3.
REQ-007 Event priority SHALL be: bus_hold_req_i > jump > data hazard.
REQ-008 bus_hold_req_i=1 in any state SHALL go to BUS_HOLD next cycle; in BUS_HOLD, hold_o is all ones, flush_o is zero, and jump_flag_o is 0.
REQ-009 A jump_flag_i seen in BUS_HOLD SHALL be latched, together with jump_addr_i, into a one-entry pending register; a later jump in the same hold overwrites it.
REQ-010 When bus_hold_req_i falls, the FSM SHALL go to JUMP_PEND if a jump is pending, else to RUN.
REQ-011 JUMP_PEND SHALL last exactly one cycle: jump_flag_o=1, jump_addr_o=latched address, flush_o bits 1..FLUSH_DEPTH set, pending cleared; then RUN.
REQ-012 In RUN or LOAD_STALL, jump_flag_i=1 SHALL be passed combinationally to jump_flag_o/jump_addr_o with flush_o bits 1..FLUSH_DEPTH set in the same cycle; a jump overrides any concurrent hazard stall.
REQ-013 A hazard match SHALL require rsN_re=1, rsN != 0, and we=1 with rd equal to rsN; index 0 never matches.
REQ-014 On a load-use hazard (match on ex with ex_is_load_i=1), the block SHALL set hold_o[1:0]=11 and flush_o[2]=1 and enter LOAD_STALL; the hazard is re-evaluated every cycle, and the block returns to RUN when it clears.
REQ-015 jump_addr_o SHALL be 0 whenever jump_flag_o=0.
REQ-016 stall_cnt_o SHALL increment by 1 on every cycle where any hold_o bit is 1, and saturate at 0xFFFF.
REQ-017 flush_o and hold_o SHALL never both be 1 for the same bit; flush wins.

Reset
REQ-018 rst=0 SHALL immediately force state RUN, clear the pending register and stall_cnt_o to 0, and drive hold_o=0, flush_o=0, jump_flag_o=0, jump_addr_o=0 and fwd sels=0, independent of clk.
REQ-019 Reset asserted during BUS_HOLD with a pending jump SHALL discard that jump; no jump_flag_o follows release.

Configuration
REQ-020 Macro PIPE_CTRL_FORWARD_EN SHALL select the forwarding behaviour.
REQ-021 With PIPE_CTRL_FORWARD_EN defined:
  - fwd sel = 1 on a non-load ex match;
  - else 2 on a mem match;
  - else 0;
  - only load-use hazards stall.
REQ-022 With PIPE_CTRL_FORWARD_EN undefined:
  - fwd sels are tied to 0;
  - any ex or mem match stalls exactly as in REQ-014.

Verification
REQ-023 Load-use: ex_rd=5, ex_we=1, ex_is_load=1, id_rs1=5, re=1 -> hold_o=00011, flush_o=00100, state=1 for 1 cycle; then with ex cleared -> RUN, stall_cnt_o=1.
REQ-024 Forward (FORWARD_EN): ex_rd=7 non-load, mem_rd=7, id_rs2=7 -> fwd_rs2_sel_o=1, no hold; with ex_we=0 -> fwd_rs2_sel_o=2. Without the macro, the same stimulus -> hold_o=00011.
REQ-025 Jump in a bus hold: bus_hold_req_i high for 4 cycles with jump_flag_i=1, addr 0x100 in cycle 2 -> jump_flag_o=0 during the hold; one cycle after release jump_flag_o=1, addr 0x100, flush_o=00110; stall_cnt_o=4.
REQ-026 Jump plus load-use in the same cycle -> jump_flag_o=1, flush_o=00110, hold_o=0, state stays RUN.
REQ-027 rst pulsed low mid-BUS_HOLD with a jump pending -> all outputs 0 asynchronously; after release no jump_flag_o is issued and stall_cnt_o=0.
